lock_keypad_scanner: RTL

//  Transmit side of the lock's digit-entry interface: scans a 4x4 matrix keypad,

---
 rtl/lock_keypad_scanner.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lock_keypad_scanner.sv
// 4x4 keypad scanner with debounce; emits one key code per press with a 1-cycle strobe.
// Optional auto-repeat while a key is held: define LOCK_KEY_REPEAT_EN.
module lock_keypad_scanner #(
    parameter int SCAN_DWELL      = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 256
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Row,
    output logic [3:0] Col,
    output logic [3:0] Key_Code,
    output logic       Key_Valid,
    output logic       Key_Busy
);
    localparam int DW = $clog2(SCAN_DWELL + 1);
    localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, WAIT_RELEASE} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    row_meta_reg, row_s_reg;
    logic [1:0]    col_reg, col_next;
    logic [1:0]    row_idx_reg, row_idx_next;
    logic [DW-1:0] dwell_reg, dwell_next;
    logic [BW-1:0] deb_reg, deb_next;
    logic [3:0]    key_code_reg, key_code_next;
    logic          key_valid_reg, key_valid_next;
    logic [1:0]    low_row;

`ifdef LOCK_KEY_REPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    logic [HW-1:0] hold_reg, hold_next;
`else
    // Keeps REPEAT_DELAY referenced when no hold counter exists
    if (REPEAT_DELAY < 1) begin : g_repeat_delay_unused
    end
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            row_meta_reg  <= 4'hF;
            row_s_reg     <= 4'hF;
            state_reg     <= SCAN;
            col_reg       <= '0;
            row_idx_reg   <= '0;
            dwell_reg     <= '0;
            deb_reg       <= '0;
            key_code_reg  <= 4'hF;
            key_valid_reg <= 1'b0;
`ifdef LOCK_KEY_REPEAT_EN
            hold_reg      <= '0;
`endif
        end else begin
            row_meta_reg  <= Row;
            row_s_reg     <= row_meta_reg;
            state_reg     <= state_next;
            col_reg       <= col_next;
            row_idx_reg   <= row_idx_next;
            dwell_reg     <= dwell_next;
            deb_reg       <= deb_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
`ifdef LOCK_KEY_REPEAT_EN
            hold_reg      <= hold_next;
`endif
        end
    end

    // Lowest-index active-low row wins when several rows are low
    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s_reg[i]) low_row = 2'(i);
        end
    end

    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        row_idx_next   = row_idx_reg;
        dwell_next     = dwell_reg;
        deb_next       = deb_reg;
        key_code_next  = key_code_reg;
        key_valid_next = 1'b0;
`ifdef LOCK_KEY_REPEAT_EN
        hold_next      = '0;
`endif
        case (state_reg)
            SCAN: begin
                if (dwell_reg == DW'(SCAN_DWELL - 1)) begin
                    dwell_next = '0;
                    if (row_s_reg != 4'hF) begin
                        state_next   = DEBOUNCE;
                        row_idx_next = low_row;
                        deb_next     = '0;
                    end else begin
                        col_next = col_reg + 2'd1;
                    end
                end else begin
                    dwell_next = dwell_reg + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_s_reg[row_idx_reg]) begin
                    state_next = SCAN;
                    col_next   = col_reg + 2'd1;
                    deb_next   = '0;
                    dwell_next = '0;
                end else if (deb_reg == BW'(DEBOUNCE_CYCLES - 1)) begin
                    // Load code and strobe together so both are valid in PRESSED
                    state_next     = PRESSED;
                    deb_next       = '0;
                    key_code_next  = {row_idx_reg, col_reg};
                    key_valid_next = 1'b1;
                end else begin
                    deb_next = deb_reg + 1'b1;
                end
            end
            PRESSED: begin
                state_next = WAIT_RELEASE;
                deb_next   = '0;
            end
            WAIT_RELEASE: begin
                if (!row_s_reg[row_idx_reg]) begin
                    deb_next = '0;
`ifdef LOCK_KEY_REPEAT_EN
                    if (hold_reg == HW'(REPEAT_DELAY - 1)) begin
                        key_valid_next = 1'b1;
                    end else begin
                        hold_next = hold_reg + 1'b1;
                    end
`endif
                end else if (deb_reg == BW'(DEBOUNCE_CYCLES - 1)) begin
                    state_next = SCAN;
                    col_next   = '0;
                    dwell_next = '0;
                    deb_next   = '0;
                end else begin
                    deb_next = deb_reg + 1'b1;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_col_drive
        assign Col[gi] = (col_reg != 2'(gi));
    end

    assign Key_Code  = key_code_reg;
    assign Key_Valid = key_valid_reg;
    assign Key_Busy  = (state_reg != SCAN);
endmodule
